// File: rtl/spi_slave_if.sv
// Parallel-side bundle for spi_slave: tx word handshake, rx word handshake
// and the frame-in-progress flag. The slave modport is the SPI responder,
// the master modport is the local logic that feeds and drains it.
interface spi_slave_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  busy;

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, busy
   );

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first. sclk/ss_n/mosi are
// oversampled in the clk domain; one tx word is buffered ahead of the
// shifter so consecutive words in one ss_n frame need no gaps.
// Optional build macro SPI_SLAVE_OVERRUN_EN: adds a sticky rx_overrun
// output and drops (instead of overwriting with) words that complete while
// the previous rx word is still pending.
// rst_n is asynchronous and active-high.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_IDLE | after reset; ignore any frame until ss_n is seen high
// IDLE      | no frame, miso low, waiting for ss_n fall
// LOAD      | one cycle: load shifter from buffer (or IDLE_TX), drive MSB
// ACTIVE    | shifting on synchronized sclk edges until ss_n rises
module spi_slave #(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] IDLE_TX    = '1
) (
   input  logic        clk,
   input  logic        rst_n,
   spi_slave_if.slave  bus,
   input  logic        sclk,
   input  logic        ss_n,
   input  logic        mosi,
   output logic        miso
`ifdef SPI_SLAVE_OVERRUN_EN
   ,
   output logic        rx_overrun
`endif
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      LOAD,
      ACTIVE
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            sclk_sync_q;
   logic [2:0]            ss_sync_q;
   logic [1:0]            mosi_sync_q;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  buf_full_q, buf_full_d;
   logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
   logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  miso_q, miso_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic                  overrun_q, overrun_d;
`endif

   logic                  sclk_rise, sclk_fall;
   logic                  ss_s, ss_rise, ss_fall;
   logic                  mosi_s;
   logic                  load_req;
   logic                  word_done;
   logic [DATA_WIDTH-1:0] next_word;
   logic [DATA_WIDTH-1:0] rx_word;

   // ss_n synchronizer resets low so a frame already running at reset
   // release is not mistaken for a fresh ss_n fall.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], sclk};
         ss_sync_q   <= {ss_sync_q[1:0], ss_n};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
      end
   end

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign ss_s      = ss_sync_q[1];
   assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
   assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
   assign mosi_s    = mosi_sync_q[1];

   // State register.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= WAIT_IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         shift_tx_q <= '0;
         shift_rx_q <= '0;
         cnt_q      <= '0;
         miso_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
         overrun_q  <= 1'b0;
`endif
      end else begin
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         shift_tx_q <= shift_tx_d;
         shift_rx_q <= shift_rx_d;
         cnt_q      <= cnt_d;
         miso_q     <= miso_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
         overrun_q  <= overrun_d;
`endif
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      shift_tx_d = shift_tx_q;
      shift_rx_d = shift_rx_q;
      cnt_d      = cnt_q;
      miso_d     = miso_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_d  = overrun_q;
`endif
      load_req   = 1'b0;
      word_done  = 1'b0;
      next_word  = buf_full_q ? buf_q : IDLE_TX;
      rx_word    = {shift_rx_q[DATA_WIDTH-2:0], mosi_s};

      if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

      case (state_q)
         WAIT_IDLE: begin
            miso_d = 1'b0;
            cnt_d  = '0;
            if (ss_s) state_d = IDLE;
         end
         IDLE: begin
            miso_d = 1'b0;
            cnt_d  = '0;
            if (ss_fall) state_d = LOAD;
         end
         LOAD: begin
            load_req   = 1'b1;
            shift_tx_d = next_word;
            miso_d     = next_word[DATA_WIDTH-1];
            cnt_d      = '0;
            state_d    = ACTIVE;
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d = IDLE;
               cnt_d   = '0;
               miso_d  = 1'b0;
            end else if (sclk_rise) begin
               shift_rx_d = rx_word;
               cnt_d      = cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_WIDTH - 1)) word_done = 1'b1;
            end else if (sclk_fall && (cnt_q != '0)) begin
               if (cnt_q == CW'(DATA_WIDTH)) begin
                  load_req   = 1'b1;
                  shift_tx_d = next_word;
                  miso_d     = next_word[DATA_WIDTH-1];
                  cnt_d      = '0;
               end else begin
                  shift_tx_d = shift_tx_q << 1;
                  miso_d     = shift_tx_q[DATA_WIDTH-2];
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase

      // A load sees the buffer as it was this cycle; a word captured in the
      // same cycle (only possible when empty) waits for the next load.
      if (load_req && buf_full_q) begin
         buf_full_d = 1'b0;
      end else if (bus.tx_valid && !buf_full_q) begin
         buf_d      = bus.tx_data;
         buf_full_d = 1'b1;
      end

`ifdef SPI_SLAVE_OVERRUN_EN
      // The pending word only counts as overrun if it is not being taken
      // in this very cycle.
      if (word_done) begin
         if (rx_valid_q && !bus.rx_ready) begin
            overrun_d = 1'b1;
         end else begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
         end
      end
`else
      if (word_done) begin
         rx_data_d  = rx_word;
         rx_valid_d = 1'b1;
      end
`endif
   end

   assign bus.tx_ready = ~buf_full_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = (state_q == LOAD) || (state_q == ACTIVE);
   assign miso         = miso_q;
`ifdef SPI_SLAVE_OVERRUN_EN
   assign rx_overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural mode-0 SPI master drives the slave,
// expected rx words and expected miso words go to scoreboard queues and are
// compared against what the slave delivers.
module tb_spi_slave;
   localparam int DW = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic sclk  = 1'b0;
   logic ss_n  = 1'b1;
   logic mosi  = 1'b0;
   logic miso;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic rx_overrun;
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] mexp_q[$];

   spi_slave_if #(.DATA_WIDTH(DW)) bus();

   spi_slave #(.DATA_WIDTH(DW), .IDLE_TX(8'hFF)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave),
      .sclk(sclk),
      .ss_n(ss_n),
      .mosi(mosi),
      .miso(miso)
`ifdef SPI_SLAVE_OVERRUN_EN
      ,
      .rx_overrun(rx_overrun)
`endif
   );

   always #5 clk = ~clk;

   // collect every accepted rx word
   always @(negedge clk) begin
      if (!rst_n && bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] d);
      int k;
      k = 0;
      while (!bus.tx_ready && k < 100) begin tick(); k++; end
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
   endtask

   task automatic frame_begin();
      ss_n = 1'b0;
      repeat (8) tick();
   endtask

   task automatic frame_end();
      repeat (6) tick();
      ss_n = 1'b1;
      repeat (12) tick();
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < n; i++) begin
         mosi = mo[7-i];
         repeat (6) tick();
         sclk = 1'b1;
         mi[7-i] = miso;
         repeat (6) tick();
         sclk = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", bus.tx_ready); end
      total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
      total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", bus.rx_data); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", miso); end
`ifdef SPI_SLAVE_OVERRUN_EN
      total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", rx_overrun); end
`endif
      tick();
      rst_n = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_loopback();
      logic [7:0] mi, e, g;
      push_tx(8'hA5);
      mexp_q.push_back(8'hA5);
      @(negedge clk);
      total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL loop_tx_ready_full got=%b want=0", bus.tx_ready); end
      tick();
      frame_begin();
      @(negedge clk);
      total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL loop_tx_ready_after_load got=%b want=1", bus.tx_ready); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL loop_busy got=%b want=1", bus.busy); end
      tick();
      exp_q.push_back(8'h3C);
      spi_bits(8'h3C, 8, mi);
      frame_end();
      e = mexp_q.pop_front();
      total++; if (mi !== e) begin bad++; $display("FAIL loop_master_rx got=%h want=%h", mi, e); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL loop_rx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL loop_rx_data got=none want=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL loop_rx_data got=%h want=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_underrun();
      logic [7:0] mi, e, g;
      mexp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      frame_begin();
      spi_bits(8'h00, 8, mi);
      frame_end();
      e = mexp_q.pop_front();
      total++; if (mi !== e) begin bad++; $display("FAIL underrun_master_rx got=%h want=%h", mi, e); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL underrun_rx_data got=none want=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL underrun_rx_data got=%h want=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1, m2, e, g;
      push_tx(8'h11);
      mexp_q.push_back(8'h11);
      mexp_q.push_back(8'h22);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'h5A);
      frame_begin();
      push_tx(8'h22);
      spi_bits(8'hC3, 8, m1);
      spi_bits(8'h5A, 8, m2);
      frame_end();
      e = mexp_q.pop_front();
      total++; if (m1 !== e) begin bad++; $display("FAIL b2b_master_rx0 got=%h want=%h", m1, e); end
      e = mexp_q.pop_front();
      total++; if (m2 !== e) begin bad++; $display("FAIL b2b_master_rx1 got=%h want=%h", m2, e); end
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_rx_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL b2b_rx_data got=none want=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL b2b_rx_data got=%h want=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_abort();
      logic [7:0] mi, e, g;
      frame_begin();
      push_tx(8'h5E);
      spi_bits(8'hB4, 4, mi);
      repeat (6) tick();
      ss_n = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
      repeat (10) tick();
      total++; if (got_q.size() != 0) begin bad++; $display("FAIL abort_rx_count got=%0d want=0", got_q.size()); end
      got_q.delete();
      mexp_q.push_back(8'h5E);
      exp_q.push_back(8'h96);
      frame_begin();
      spi_bits(8'h96, 8, mi);
      frame_end();
      e = mexp_q.pop_front();
      total++; if (mi !== e) begin bad++; $display("FAIL abort_kept_buffer got=%h want=%h", mi, e); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL abort_next_rx got=none want=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL abort_next_rx got=%h want=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_overrun();
      logic [7:0] mi, e, g;
      int k;
      bus.rx_ready = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      exp_q.push_back(8'h01);
`else
      exp_q.push_back(8'h02);
`endif
      frame_begin();
      spi_bits(8'h01, 8, mi);
      frame_end();
      frame_begin();
      spi_bits(8'h02, 8, mi);
      frame_end();
      @(negedge clk);
      total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_rx_valid got=%b want=1", bus.rx_valid); end
      total++; if (bus.rx_data !== exp_q[0]) begin bad++; $display("FAIL ovr_rx_data got=%h want=%h", bus.rx_data, exp_q[0]); end
`ifdef SPI_SLAVE_OVERRUN_EN
      total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", rx_overrun); end
`endif
      tick();
      bus.rx_ready = 1'b1;
      k = 0;
      while (got_q.size() < 1 && k < 50) begin tick(); k++; end
      repeat (3) tick();
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL ovr_rx_count got=%0d want=1", got_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL ovr_popped got=none want=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL ovr_popped got=%h want=%h", g, e); end end
      end
      got_q.delete();
      @(negedge clk);
      total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_rx_valid_clear got=%b want=0", bus.rx_valid); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] mi, e, g;
      frame_begin();
      spi_bits(8'hE7, 3, mi);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_rx_data got=%h want=00", bus.rx_data); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", bus.busy); end
      total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_tx_ready got=%b want=1", bus.tx_ready); end
      total++; if (miso !== 1'b0) begin bad++; $display("FAIL mid_rst_miso got=%b want=0", miso); end
`ifdef SPI_SLAVE_OVERRUN_EN
      total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL mid_rst_overrun got=%b want=0", rx_overrun); end
`endif
      tick();
      rst_n = 1'b0;
      spi_bits(8'hFF, 5, mi);
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_ignored_busy got=%b want=0", bus.busy); end
      tick();
      frame_end();
      total++; if (got_q.size() != 0) begin bad++; $display("FAIL mid_ignored_rx got=%0d want=0", got_q.size()); end
      got_q.delete();
      mexp_q.push_back(8'hFF);
      exp_q.push_back(8'hE7);
      frame_begin();
      spi_bits(8'hE7, 8, mi);
      frame_end();
      e = mexp_q.pop_front();
      total++; if (mi !== e) begin bad++; $display("FAIL mid_next_master_rx got=%h want=%h", mi, e); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL mid_next_rx got=none want=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL mid_next_rx got=%h want=%h", g, e); end end
      end
      got_q.delete();
   endtask

   initial begin
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      bus.rx_ready = 1'b1;
      test_reset();
      test_loopback();
      test_underrun();
      test_back_to_back();
      test_abort();
      test_overrun();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
